// File: rtl/hdr_read_scheduler_if.sv
// hdr_read_scheduler_if: SDRAM read command/data channel plus the pixel FIFO write port
// of the HDR read scheduler; master is the scheduler, slave is the memory/FIFO side.
interface hdr_read_scheduler_if #(
    parameter int ADDR_W = 24
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              mem_rd_valid;
    logic [127:0]      mem_rd_data;
    logic [127:0]      data_high;
    logic [127:0]      data_mid;
    logic [127:0]      data_low;
    logic              rd_valid;

    modport master (
        output cmd_valid, cmd_addr, data_high, data_mid, data_low, rd_valid,
        input  cmd_ready, mem_rd_valid, mem_rd_data
    );
    modport slave (
        input  cmd_valid, cmd_addr, data_high, data_mid, data_low, rd_valid,
        output cmd_ready, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/hdr_read_scheduler.sv
// hdr_read_scheduler: reads high/mid/low exposure words per offset from SDRAM, one outstanding
// read at a time, and pushes aligned triples to the pixel FIFO under credit throttling.
module hdr_read_scheduler #(
    parameter int                ADDR_W          = 24,
    parameter logic [ADDR_W-1:0] BASE_HIGH       = 24'h000000,
    parameter logic [ADDR_W-1:0] BASE_MID        = 24'h010000,
    parameter logic [ADDR_W-1:0] BASE_LOW        = 24'h020000,
    parameter int                WORDS_PER_FRAME = 38400,
    parameter int                CREDIT_MAX      = 1000
) (
    input  logic                 clk_133M,
    input  logic                 rst_n_133M,
    input  logic                 enable,
    input  logic                 frame_start,
    input  logic                 credit_return,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 err,
    hdr_read_scheduler_if.master bus
);
    localparam int OFF_W  = $clog2(WORDS_PER_FRAME);
    localparam int CRED_W = $clog2(CREDIT_MAX + 1);

    typedef enum logic [3:0] {IDLE, GATE, REQ_H, WAIT_H, REQ_M, WAIT_M, REQ_L, WAIT_L, PUSH} state_t;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [CRED_W-1:0] cred_q, cred_d;
    logic              err_q, err_d;
    logic [127:0]      high_q, high_d, mid_q, mid_d, low_q, low_d;
    logic              last, push, wait_st;
    logic [ADDR_W-1:0] base;

    assign last    = offset_q == OFF_W'(WORDS_PER_FRAME - 1);
    assign push    = state_q == PUSH;
    assign wait_st = state_q inside {WAIT_H, WAIT_M, WAIT_L};

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            state_q  <= IDLE;
            offset_q <= '0;
            cred_q   <= '0;
            err_q    <= 1'b0;
            high_q   <= '0;
            mid_q    <= '0;
            low_q    <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            cred_q   <= cred_d;
            err_q    <= err_d;
            high_q   <= high_d;
            mid_q    <= mid_d;
            low_q    <= low_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        high_d   = high_q;
        mid_d    = mid_q;
        low_d    = low_q;
        case (state_q)
            IDLE:   if (frame_start) begin
                        state_d  = GATE;
                        offset_d = '0;
                    end
            GATE:   if (enable && cred_q < CRED_W'(CREDIT_MAX)) state_d = REQ_H;
            REQ_H:  if (bus.cmd_ready) state_d = WAIT_H;
            WAIT_H: if (bus.mem_rd_valid) begin
                        high_d  = bus.mem_rd_data;
                        state_d = REQ_M;
                    end
            REQ_M:  if (bus.cmd_ready) state_d = WAIT_M;
            WAIT_M: if (bus.mem_rd_valid) begin
                        mid_d   = bus.mem_rd_data;
                        state_d = REQ_L;
                    end
            REQ_L:  if (bus.cmd_ready) state_d = WAIT_L;
            WAIT_L: if (bus.mem_rd_valid) begin
                        low_d   = bus.mem_rd_data;
                        state_d = PUSH;
                    end
            PUSH:   begin
                        state_d  = last ? IDLE : GATE;
                        offset_d = last ? '0 : offset_q + 1'b1;
                    end
            default: state_d = IDLE;
        endcase
    end

    // a simultaneous push and return cancel; a return with no credits held is ignored
    assign cred_d = (push && !credit_return) ? cred_q + 1'b1 :
                    (!push && credit_return && cred_q != '0) ? cred_q - 1'b1 : cred_q;
    assign err_d  = err_q | (bus.mem_rd_valid & ~wait_st);

    assign base = (state_q inside {REQ_M, WAIT_M}) ? BASE_MID :
                  (state_q inside {REQ_L, WAIT_L}) ? BASE_LOW : BASE_HIGH;

    assign bus.cmd_valid = state_q inside {REQ_H, REQ_M, REQ_L};
    assign bus.cmd_addr  = base + ADDR_W'(offset_q);
    assign bus.data_high = high_q;
    assign bus.data_mid  = mid_q;
    assign bus.data_low  = low_q;
    assign bus.rd_valid  = push;
    assign frame_done    = push & last;
    assign busy          = state_q != IDLE;
    assign err           = err_q;
endmodule

// File: doc/hdr_read_scheduler.md
# hdr_read_scheduler

Sequences exposure-frame reads from SDRAM into the three-lane pixel FIFO in the 133 MHz domain. For each 128-bit word offset it issues one read to each of the high, mid and low exposure frame buffers, in that order, and captures the returned words. It then presents the aligned triple with a single write strobe to the pixel buffer. It throttles on a credit count of triples resident in the FIFO, so the 10-bit-deep FIFOs never overflow.

## Interface
- ADDR_W, 24, memory word-address width
- BASE_HIGH, 24'h000000, word base address of high-exposure frame
- BASE_MID, 24'h010000, word base address of mid-exposure frame
- BASE_LOW, 24'h020000, word base address of low-exposure frame
- WORDS_PER_FRAME, 38400, 128-bit words per frame (640x480x16 bit / 128)
- CREDIT_MAX, 1000, maximum triples allowed in the pixel FIFO (depth 1024, margin 24)

Ports:
- clk_133M  in  1  sole clock; all logic on rising edge
- rst_n_133M  in  1  asynchronous, active-low reset
- enable  in  1  level; 0 stalls new triples, and any in-flight triple completes
- frame_start  in  1  pulse; starts a frame from offset 0, honoured only in IDLE
- credit_return  in  1  pulse, already synchronised to clk_133M; one triple read from the FIFO
- cmd_valid  out  1  read request valid
- cmd_ready  in  1  memory controller accepts the request
- cmd_addr  out  ADDR_W  word address of the request
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  128  read data
- data_high, data_mid, data_low  out  128 each  captured triple to the pixel FIFO
- rd_valid  out  1  write strobe for all three FIFOs
- frame_done  out  1  one-cycle pulse after the last triple of a frame
- busy  out  1  high in every state except IDLE
- err  out  1  sticky; set by mem_rd_valid outside a WAIT state, cleared only by reset

## Operation
- States:
  - IDLE: frame_start -> GATE, offset <= 0
  - GATE: enable && credits < CREDIT_MAX -> REQ_H; otherwise stay
  - REQ_H -> WAIT_H -> REQ_M -> WAIT_M -> REQ_L -> WAIT_L -> PUSH
  - PUSH: last offset -> IDLE; otherwise -> GATE
- REQ_x:
  - cmd_valid=1, cmd_addr = BASE_x + offset, truncated modulo 2^ADDR_W.
  - Held stable until cmd_ready; on the handshake cycle, go to WAIT_x.
- WAIT_x: on mem_rd_valid, mem_rd_data is registered into data_x and the FSM advances. Exactly one outstanding read at a time.
- PUSH:
  - rd_valid=1 for one cycle; data_high/mid/low hold the triple.
  - Credit counter increments.
  - If offset == WORDS_PER_FRAME-1: frame_done=1, offset <= 0, next IDLE.
  - Otherwise offset <= offset+1, next GATE.
- Credit counter:
  - Width clog2(CREDIT_MAX+1).
  - +1 on PUSH; -1 on credit_return.
  - Both in the same cycle: unchanged.
  - credit_return at 0: saturates at 0 and does not set err.
- frame_start outside IDLE is ignored and not queued.
- enable deassertion only blocks the GATE -> REQ_H transition.
- mem_rd_valid outside WAIT_x: data dropped, err <= 1, state unchanged.
- data_x registers hold their last value until overwritten.

## Timing
- Reset values:
  - State IDLE, offset 0, credits 0.
  - cmd_valid, rd_valid, frame_done, busy, err = 0.
  - cmd_addr = BASE_HIGH; data_* = 0.
- All outputs are registered or decoded from state, with no combinational path from input to output.
- Minimum triple period with cmd_ready=1 and zero-latency data: GATE, REQ_H, WAIT_H, REQ_M, WAIT_M, REQ_L, WAIT_L, PUSH = 8 cycles.
- rd_valid appears the cycle after the low word is captured.
- frame_done coincides with the final rd_valid.
- frame_start to first cmd_valid: 2 cycles (IDLE->GATE->REQ_H), given enable and credit.
- Asynchronous reset mid-frame: immediate return to IDLE. The partial triple is discarded and any outstanding memory read is dropped. The memory controller and pixel FIFO are reset in the same domain.

## Test plan
- Reset, then frame_start with WORDS_PER_FRAME=4, cmd_ready=1, data 1-cycle latency:
  - 12 requests at 0x000000, 0x010000, 0x020000, then 0x000001, ...
  - 4 rd_valid pulses.
  - frame_done on the 4th pulse; busy falls the next cycle.
- Memory returns 128'hA.., 128'hB.., 128'hC.. for offset 0 -> rd_valid with data_high=A, data_mid=B, data_low=C in the same cycle.
- CREDIT_MAX=2, no credit_return:
  - Exactly 2 rd_valid, then the FSM parks in GATE with cmd_valid=0.
  - One credit_return pulse -> cmd_valid at 0x000002 two cycles later.
- cmd_ready held low 5 cycles in REQ_M -> cmd_valid and cmd_addr stay at 0x010000 for all 5 cycles; no duplicate request.
- mem_rd_valid pulsed while in GATE -> err=1 and stays 1; the next triple is still correct.
- Assert rst_n_133M low during WAIT_M of offset 7, release, then frame_start -> first request at 0x000000 with credits=0 and err=0.
